// File: rtl/move_seq_pkg.sv
// rtl/move_seq_pkg.sv - shared types and widths for the knight-move sequencer
package move_seq_pkg;

  localparam int HDG_W   = 12;
  localparam int FRWRD_W = 10;

  typedef enum logic [2:0] {IDLE, TURN, RAMP_UP, RAMP_DOWN, DONE} mv_state_t;

  // Magnitude of a signed heading error; the most negative code folds to the largest positive one.
  function automatic logic [HDG_W-1:0] abs_hdg(input logic [HDG_W-1:0] e);
    if (!e[HDG_W-1]) return e;
    if (e == {1'b1, {(HDG_W-1){1'b0}}}) return {1'b0, {(HDG_W-1){1'b1}}};
    return -e;
  endfunction

endpackage

// File: rtl/move_sequencer_spd_ramp.sv
// rtl/move_sequencer_spd_ramp.sv - forward-speed register with saturating ramp up/down
module spd_ramp
  import move_seq_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               up,
  input  logic               dn,
  input  logic [FRWRD_W-1:0] step,
  input  logic [FRWRD_W-1:0] max,
  output logic [FRWRD_W-1:0] frwrd
);

  logic [FRWRD_W:0] sum;
  logic [FRWRD_W:0] step2;

  assign sum   = {1'b0, frwrd} + {1'b0, step};
  assign step2 = {step, 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frwrd <= '0;
    end else if (clr) begin
      frwrd <= '0;
    end else if (up) begin
      frwrd <= (sum > {1'b0, max}) ? max : sum[FRWRD_W-1:0];
    end else if (dn) begin
      // Decrement is twice the ramp-up step and floors at zero.
      frwrd <= ({1'b0, frwrd} <= step2) ? '0 : frwrd - step2[FRWRD_W-1:0];
    end
  end

endmodule

// File: rtl/move_sequencer.sv
// rtl/move_sequencer.sv - sequences one knight move: turn, ramp up, count squares, ramp down
module move_sequencer
  import move_seq_pkg::*;
#(
  parameter logic [FRWRD_W-1:0] FRWRD_INC   = 10'h004,
  parameter logic [FRWRD_W-1:0] FRWRD_MAX   = 10'h300,
  parameter logic [HDG_W-1:0]   TURN_THRESH = 12'h02C
)(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mv_vld,
  input  logic [HDG_W-1:0]   mv_hdg,
  input  logic [2:0]         mv_sqrs,
  input  logic               mv_abort,
  input  logic [HDG_W-1:0]   heading,
  input  logic               heading_rdy,
  input  logic               cntrIR,
  output logic               mv_ack,
  output logic               mv_done,
  output logic               moving,
  output logic               err_vld,
  output logic [HDG_W-1:0]   error,
  output logic [FRWRD_W-1:0] frwrd
);

  mv_state_t        state;
  logic [HDG_W-1:0] hdg_lat;
  logic [2:0]       sqrs_lat;
  logic [2:0]       sq_cnt;
  logic             cntr_ff;
  logic             rise;
  logic [HDG_W-1:0] abs_err;

  assign error   = heading - hdg_lat;
  assign abs_err = abs_hdg(error);
  assign err_vld = heading_rdy & moving;
  assign rise    = cntrIR & ~cntr_ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cntr_ff <= 1'b0;
    else        cntr_ff <= cntrIR;
  end

  spd_ramp u_spd_ramp (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   ((state != RAMP_UP) && (state != RAMP_DOWN)),
    .up    ((state == RAMP_UP) && heading_rdy),
    .dn    ((state == RAMP_DOWN) && heading_rdy),
    .step  (FRWRD_INC),
    .max   (FRWRD_MAX),
    .frwrd (frwrd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      hdg_lat  <= '0;
      sqrs_lat <= '0;
      sq_cnt   <= '0;
      mv_ack   <= 1'b0;
      mv_done  <= 1'b0;
      moving   <= 1'b0;
    end else begin
      mv_ack  <= 1'b0;
      mv_done <= 1'b0;
      case (state)
        IDLE: begin
          if (mv_vld && !mv_abort) begin
            hdg_lat  <= mv_hdg;
            sqrs_lat <= mv_sqrs;
            sq_cnt   <= '0;
            mv_ack   <= 1'b1;
            moving   <= 1'b1;
            state    <= TURN;
          end
        end
        TURN: begin
          if (mv_abort || (heading_rdy && abs_err < TURN_THRESH && sqrs_lat == 3'd0)) begin
            moving  <= 1'b0;
            mv_done <= 1'b1;
            state   <= DONE;
          end else if (heading_rdy && abs_err < TURN_THRESH) begin
            state <= RAMP_UP;
          end
        end
        RAMP_UP: begin
          if (rise) sq_cnt <= sq_cnt + 3'd1;
          // Count is compared registered, so the exit follows the final crossing by one cycle.
          if (mv_abort || sq_cnt == sqrs_lat) state <= RAMP_DOWN;
        end
        RAMP_DOWN: begin
          if (frwrd == '0) begin
            moving  <= 1'b0;
            mv_done <= 1'b1;
            state   <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_move_sequencer.sv
// tb/tb_move_sequencer.sv - randomized self-checking bench for move_sequencer
module tb_move_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mv_vld;
  logic [11:0] mv_hdg;
  logic [2:0]  mv_sqrs;
  logic        mv_abort;
  logic [11:0] heading;
  logic        heading_rdy;
  logic        cntrIR;
  logic        mv_ack;
  logic        mv_done;
  logic        moving;
  logic        err_vld;
  logic [11:0] error;
  logic [9:0]  frwrd;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  move_sequencer dut (
    .clk(clk), .rst_n(rst_n), .mv_vld(mv_vld), .mv_hdg(mv_hdg), .mv_sqrs(mv_sqrs),
    .mv_abort(mv_abort), .heading(heading), .heading_rdy(heading_rdy), .cntrIR(cntrIR),
    .mv_ack(mv_ack), .mv_done(mv_done), .moving(moving), .err_vld(err_vld),
    .error(error), .frwrd(frwrd)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_move(input logic [11:0] h, input logic [2:0] s);
    mv_hdg  = h;
    mv_sqrs = s;
    mv_vld  = 1'b1;
    tick();
    mv_vld  = 1'b0;
  endtask

  task automatic strobe;
    heading_rdy = 1'b1;
    tick();
    heading_rdy = 1'b0;
  endtask

  task automatic rise_pulse;
    cntrIR = 1'b1;
    tick();
    cntrIR = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    rst_n = 1'b0; mv_vld = 0; mv_hdg = 0; mv_sqrs = 0; mv_abort = 0;
    heading = 0; heading_rdy = 0; cntrIR = 0;
    tick(); tick();
    checks++;
    if ({mv_ack, mv_done, moving, err_vld, frwrd, error} !== 26'd0) begin
      failures++; $display("FAIL reset_outputs got=%h exp=0", {mv_ack, mv_done, moving, err_vld, frwrd, error});
    end
    rst_n = 1'b1;
    tick();
    start_move(12'h000, 3'd3);
    strobe();
    for (int k = 0; k < 16; k++) strobe();
    checks++;
    if (frwrd !== 10'h040) begin failures++; $display("FAIL reset_pre_frwrd got=%h exp=040", frwrd); end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({mv_ack, mv_done, moving, err_vld, frwrd, error} !== 26'd0) begin
      failures++; $display("FAIL reset_async got=%h exp=0", {mv_ack, mv_done, moving, err_vld, frwrd, error});
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_turn_only;
    heading = 12'h100;
    start_move(12'h000, 3'd0);
    checks++;
    if ({mv_ack, moving} !== 2'b11 || error !== 12'h100) begin
      failures++; $display("FAIL turn_ack got=%b%b err=%h exp=11 err=100", mv_ack, moving, error);
    end
    tick();
    checks++;
    if (mv_ack !== 1'b0) begin failures++; $display("FAIL turn_ack_pulse got=%b exp=0", mv_ack); end
    for (int k = 0; k < 3; k++) begin
      heading_rdy = 1'b1;
      #1;
      checks++;
      if (err_vld !== 1'b1) begin failures++; $display("FAIL turn_err_vld got=%b exp=1", err_vld); end
      tick();
      heading_rdy = 1'b0;
      checks++;
      if ({mv_done, moving} !== 2'b01 || frwrd !== 10'd0) begin
        failures++; $display("FAIL turn_hold got=%b%b f=%h exp=01 f=0", mv_done, moving, frwrd);
      end
    end
    heading = 12'h010;
    strobe();
    checks++;
    if ({mv_done, moving} !== 2'b10 || frwrd !== 10'd0) begin
      failures++; $display("FAIL turn_done got=%b%b f=%h exp=10 f=0", mv_done, moving, frwrd);
    end
    tick();
    checks++;
    if (mv_done !== 1'b0) begin failures++; $display("FAIL turn_done_pulse got=%b exp=0", mv_done); end
  endtask

  task automatic test_ramp;
    for (int it = 0; it < 3; it++) begin
      logic [11:0] hdg;
      int n_up, f;
      hdg = 12'($urandom);
      heading = hdg;
      n_up = (it == 0) ? 200 : $urandom_range(20, 200);
      start_move(hdg, 3'd2);
      strobe();
      f = 0;
      for (int k = 1; k <= n_up; k++) begin
        strobe();
        f = (f + 4 > 768) ? 768 : f + 4;
        checks++;
        if (frwrd !== 10'(f)) begin failures++; $display("FAIL ramp_up k=%0d got=%h exp=%h", k, frwrd, f); end
        if (k == 5) begin
          mv_hdg = ~hdg;
          mv_vld = 1'b1;
          tick();
          mv_vld = 1'b0;
          checks++;
          if (mv_ack !== 1'b0 || error !== 12'd0) begin
            failures++; $display("FAIL ramp_vld_ignored ack=%b err=%h exp ack=0 err=0", mv_ack, error);
          end
        end
        repeat ($urandom_range(0, 2)) tick();
      end
      rise_pulse();
      rise_pulse();
      while (f > 0) begin
        strobe();
        f = (f < 8) ? 0 : f - 8;
        checks++;
        if (frwrd !== 10'(f) || mv_done !== 1'b0) begin
          failures++; $display("FAIL ramp_down got=%h done=%b exp=%h done=0", frwrd, mv_done, f);
        end
      end
      tick();
      checks++;
      if ({mv_done, moving} !== 2'b10) begin
        failures++; $display("FAIL ramp_done got=%b%b exp=10", mv_done, moving);
      end
      tick();
      checks++;
      if (mv_done !== 1'b0) begin failures++; $display("FAIL ramp_done_pulse got=%b exp=0", mv_done); end
    end
  endtask

  task automatic test_same_cycle;
    logic [11:0] hdg;
    int f;
    hdg = 12'($urandom);
    heading = hdg;
    start_move(hdg, 3'd2);
    strobe();
    for (int k = 0; k < 5; k++) strobe();
    heading_rdy = 1'b1;
    cntrIR = 1'b1;
    tick();
    heading_rdy = 1'b0;
    cntrIR = 1'b0;
    checks++;
    if (frwrd !== 10'd24) begin failures++; $display("FAIL same_cycle_step got=%h exp=18", frwrd); end
    tick();
    strobe();
    checks++;
    if (frwrd !== 10'd28) begin failures++; $display("FAIL same_cycle_still_up got=%h exp=1c", frwrd); end
    rise_pulse();
    strobe();
    checks++;
    if (frwrd !== 10'd20) begin failures++; $display("FAIL same_cycle_count got=%h exp=14", frwrd); end
    f = 20;
    while (f > 0) begin
      strobe();
      f = (f < 8) ? 0 : f - 8;
    end
    tick();
    checks++;
    if (mv_done !== 1'b1) begin failures++; $display("FAIL same_cycle_done got=%b exp=1", mv_done); end
    tick();
  endtask

  task automatic test_abort;
    logic [11:0] hdg;
    hdg = 12'($urandom);
    heading = hdg + 12'h200;
    mv_hdg = hdg; mv_vld = 1'b1; mv_abort = 1'b1;
    tick();
    mv_vld = 1'b0; mv_abort = 1'b0;
    checks++;
    if ({mv_ack, moving} !== 2'b00) begin failures++; $display("FAIL abort_idle got=%b%b exp=00", mv_ack, moving); end
    start_move(hdg, 3'd1);
    mv_abort = 1'b1;
    tick();
    mv_abort = 1'b0;
    checks++;
    if ({mv_done, moving} !== 2'b10) begin failures++; $display("FAIL abort_turn got=%b%b exp=10", mv_done, moving); end
    tick();
    heading = hdg;
    start_move(hdg, 3'd3);
    strobe();
    for (int k = 0; k < 3; k++) strobe();
    checks++;
    if (frwrd !== 10'h00C) begin failures++; $display("FAIL abort_ramp_pre got=%h exp=00c", frwrd); end
    mv_abort = 1'b1;
    tick();
    mv_abort = 1'b0;
    strobe();
    checks++;
    if (frwrd !== 10'h004) begin failures++; $display("FAIL abort_ramp_dn1 got=%h exp=004", frwrd); end
    strobe();
    checks++;
    if (frwrd !== 10'h000 || mv_done !== 1'b0) begin
      failures++; $display("FAIL abort_ramp_dn2 got=%h done=%b exp=000 done=0", frwrd, mv_done);
    end
    tick();
    checks++;
    if (mv_done !== 1'b1) begin failures++; $display("FAIL abort_ramp_done got=%b exp=1", mv_done); end
    tick();
  endtask

  task automatic test_wrap;
    heading = 12'h7F0;
    start_move(12'h810, 3'd0);
    checks++;
    if (error !== 12'hFE0) begin failures++; $display("FAIL wrap_error got=%h exp=fe0", error); end
    strobe();
    checks++;
    if (mv_done !== 1'b1) begin failures++; $display("FAIL wrap_exit got=%b exp=1", mv_done); end
    tick();
    for (int it = 0; it < 10; it++) begin
      logic [11:0] hdg, dl;
      int delta, mag;
      logic exp_exit;
      hdg = 12'($urandom);
      delta = (it == 0) ? -2048 : (it == 1) ? 44 : (it == 2) ? -43 : $urandom_range(0, 128) - 64;
      dl = delta[11:0];
      mag = (delta < 0) ? -delta : delta;
      if (mag > 2047) mag = 2047;
      exp_exit = (mag < 44);
      heading = hdg + dl;
      start_move(hdg, 3'd0);
      checks++;
      if (error !== dl) begin failures++; $display("FAIL wrap_rand_err d=%0d got=%h exp=%h", delta, error, dl); end
      strobe();
      checks++;
      if (mv_done !== exp_exit) begin
        failures++; $display("FAIL wrap_rand_exit d=%0d got=%b exp=%b", delta, mv_done, exp_exit);
      end
      if (!exp_exit) begin
        heading = hdg;
        strobe();
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_turn_only();
    test_ramp();
    test_same_cycle();
    test_abort();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
